// File: rtl/decode_issue_tx_pkg.sv
// Shared decode-side types for the decode-to-issue transmitter.
// Holds the address/op widths, the packed op bundle and a saturating-increment helper.
package decode_issue_tx_pkg;

    localparam int AddrWidth = 32;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
    } dec_op_t;

    localparam int DecOpWidth = $bits(dec_op_t);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dec_is_queue.sv
// Generic synchronous FIFO with wrap-bit pointers and a synchronous clear.
// Read data is the entry at the read pointer, taken straight from the storage array.
module dec_is_queue #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW-2:0] == rptr[PW-2:0]) && (wptr[PW-1] != rptr[PW-1]);

    assign rd_data = mem[rptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (reset_ || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en && !full) wptr <= wptr + 1'b1;
            if (rd_en && !empty) rptr <= rptr + 1'b1;
        end
    end

    // Storage is not reset; the head is don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wptr[PW-2:0]] <= wr_data;
    end

endmodule

// File: rtl/decode_issue_tx.sv
// Decode-to-issue transmitter: in-order queue with valid/stall handshake and flush.
// Optional perf counters are built when DEC_IS_PERF_EN is defined.
module decode_issue_tx
    import decode_issue_tx_pkg::*;
#(
    parameter int ADDR  = AddrWidth,
    parameter int OP_W  = DecOpWidth,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            flush,
    input  logic            dec_valid,
    input  logic [ADDR-1:0] dec_pc,
    input  logic [OP_W-1:0] dec_op,
    output logic            dec_ready,
    output logic            is_valid,
    output logic [ADDR-1:0] is_pc,
    output logic [OP_W-1:0] is_op,
    input  logic            is_stall
`ifdef DEC_IS_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_full_cnt
`endif
);

    logic full;
    logic empty;
    logic enq;
    logic deq;

    // Ready depends only on pointer state, never on is_stall.
    assign dec_ready = !full;
    assign is_valid  = !empty;
    assign enq       = dec_valid && dec_ready && !flush;
    assign deq       = is_valid && !is_stall && !flush;

    dec_is_queue #(
        .W     (ADDR + OP_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_  (reset_),
        .clear   (flush),
        .wr_en   (enq),
        .wr_data ({dec_pc, dec_op}),
        .rd_en   (deq),
        .rd_data ({is_pc, is_op}),
        .full    (full),
        .empty   (empty)
    );

`ifdef DEC_IS_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset_) begin
            perf_stall_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            if (is_valid && is_stall) perf_stall_cnt <= sat_inc(perf_stall_cnt);
            if (full) perf_full_cnt <= sat_inc(perf_full_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_decode_issue_tx.sv
// Randomized and directed bench for decode_issue_tx against a queue-based model.
// Perf counter checks are compiled in when DEC_IS_PERF_EN is defined.
module tb_decode_issue_tx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_ = 1'b1;
    logic        flush = 1'b0;
    logic        dec_valid = 1'b0;
    logic [31:0] dec_pc = '0;
    logic [15:0] dec_op = '0;
    logic        dec_ready;
    logic        is_valid;
    logic [31:0] is_pc;
    logic [15:0] is_op;
    logic        is_stall = 1'b0;
`ifdef DEC_IS_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_full_cnt;
`endif

    always #5 clk = ~clk;

    decode_issue_tx #(
        .ADDR  (32),
        .OP_W  (16),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .flush     (flush),
        .dec_valid (dec_valid),
        .dec_pc    (dec_pc),
        .dec_op    (dec_op),
        .dec_ready (dec_ready),
        .is_valid  (is_valid),
        .is_pc     (is_pc),
        .is_op     (is_op),
        .is_stall  (is_stall)
`ifdef DEC_IS_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_full_cnt  (perf_full_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [47:0] q[$];
    bit          known = 0;
    longint      m_stall = 0;
    longint      m_full  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, advance the model.
    task automatic step(input bit r, input bit f, input bit v,
                        input logic [31:0] pc, input bit s);
        logic [15:0] op;
        @(negedge clk);
        op = 16'($urandom);
        if (known) begin
            check("is_valid", {63'd0, is_valid}, {63'd0, q.size() > 0});
            check("dec_ready", {63'd0, dec_ready}, {63'd0, q.size() < DEPTH});
            if (q.size() > 0) check("head", {16'd0, is_pc, is_op}, {16'd0, q[0]});
`ifdef DEC_IS_PERF_EN
            check("perf_stall", {32'd0, perf_stall_cnt}, m_stall);
            check("perf_full", {32'd0, perf_full_cnt}, m_full);
`endif
        end
        reset_    = r;
        flush     = f;
        dec_valid = v;
        dec_pc    = pc;
        dec_op    = op;
        is_stall  = s;
        if (r) begin
            m_stall = 0;
            m_full  = 0;
            q.delete();
            known = 1;
        end else begin
            if (q.size() > 0 && s) m_stall++;
            if (q.size() == DEPTH) m_full++;
            if (f) begin
                q.delete();
            end else begin
                bit pop;
                bit push;
                pop  = (q.size() > 0) && !s;
                push = v && (q.size() < DEPTH);
                if (pop) void'(q.pop_front());
                if (push) q.push_back({pc, op});
            end
        end
    endtask

    initial begin
        // Reset then idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        // Single transfer
        step(0, 0, 1, 32'h100, 0);
        step(0, 0, 0, 0, 0);
        check("single_pc", {32'd0, is_pc}, 64'h100);
        step(0, 0, 0, 0, 0);

        // Fill to full with stall held
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'(i * 4), 1);
        repeat (3) step(0, 0, 1, 32'h10, 1);
        check("full_ready", {63'd0, dec_ready}, 64'd0);
        check("full_head", {32'd0, is_pc}, 64'h0);
        step(0, 0, 1, 32'h10, 0);
        step(0, 0, 1, 32'h10, 0);
        repeat (6) step(0, 0, 0, 0, 0);

        // Simultaneous enqueue/dequeue at count 2, across pointer wrap
        step(0, 0, 1, 32'h200, 1);
        step(0, 0, 1, 32'h204, 1);
        for (int i = 0; i < 3 * DEPTH; i++) step(0, 0, 1, 32'(32'h208 + i * 4), 0);
        repeat (4) step(0, 0, 0, 0, 0);

        // Flush at count 3 with concurrent enqueue
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'(32'h300 + i * 4), 1);
        step(0, 1, 1, 32'hDEAD, 1);
        step(0, 0, 0, 0, 0);
        check("flush_valid", {63'd0, is_valid}, 64'd0);
        check("flush_ready", {63'd0, dec_ready}, 64'd1);
        step(0, 0, 1, 32'h400, 0);
        step(0, 0, 0, 0, 0);
        check("post_flush_pc", {32'd0, is_pc}, 64'h400);

        // Reset mid-stream at count 2
        step(0, 0, 1, 32'h500, 1);
        step(0, 0, 1, 32'h504, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 32'h600, 1);
        step(0, 0, 0, 0, 1);
        check("post_reset_pc", {32'd0, is_pc}, 64'h600);
        repeat (2) step(0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit f;
            bit v;
            bit s;
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 4);
            v = ($urandom_range(0, 99) < 70);
            s = ($urandom_range(0, 99) < 40);
            step(r, f, v, $urandom, s);
        end
        repeat (2) step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_tx.md
# decode_issue_tx

Decoder-side transmitter for the decode-to-issue interface (`DecIsIf`). It buffers decoded instructions from the decode stage in a small in-order queue and presents them one per cycle to the instruction scheduler. Transfers use a valid/stall handshake, and the queue is cleared on pipeline flush. It sits between the decoder and `inst_sched`, and owns all back-pressure toward decode.

## Interface
Parameters:
- `ADDR`, `` `AddrWidth ``: PC width.
- `OP_W`, `` `DecOpWidth ``: width of packed decoded-op bundle `dec_op_t`.
- `DEPTH`, 4: queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_`  in  1  synchronous, active-high reset. Asserted (1) clears state at next `clk` edge.
- `flush`  in  1  branch mispredict / exception flush.
- `dec_valid`  in  1  decoder presents an instruction.
- `dec_pc`  in  ADDR  instruction PC.
- `dec_op`  in  OP_W  decoded op bundle.
- `dec_ready`  out  1  queue can accept this cycle.
- `is_valid`  out  1  head entry valid toward scheduler.
- `is_pc`  out  ADDR  head PC.
- `is_op`  out  OP_W  head op.
- `is_stall`  in  1  scheduler cannot take head this cycle.
- `` `ifdef DEC_IS_PERF_EN ``: `perf_stall_cnt`  out  32  stall-cycle counter; `perf_full_cnt`  out  32  full-cycle counter.

## Operation
- Enqueue when `dec_valid && dec_ready`. Dequeue when `is_valid && !is_stall`.
- `dec_ready = (count != DEPTH)`. It is driven from registers only and has no combinational path from `is_stall`.
- Storage: `DEPTH`-entry array. Read/write pointers are `log2(DEPTH)+1` bits; the MSB is the wrap bit.
  - Full: pointer indices equal and wrap bits differ.
  - Empty: pointers fully equal.
  - `count = wptr - rptr`, modulo `2*DEPTH`.
- Occupancy states derived from `count`:
  - EMPTY, `count==0`: `is_valid=0`.
  - PARTIAL, `0<count<DEPTH`: enqueue and dequeue both legal.
  - FULL, `count==DEPTH`: `dec_ready=0`.
- Transitions:
  - EMPTY→PARTIAL on enqueue.
  - PARTIAL→FULL on enqueue without dequeue at `count==DEPTH-1`.
  - FULL→PARTIAL on dequeue.
  - PARTIAL→EMPTY on dequeue without enqueue at `count==1`.
- Simultaneous enqueue and dequeue: `count` unchanged, both pointers advance. When FULL, enqueue is impossible because `dec_ready=0`.
- `is_pc` and `is_op` reflect the entry at `rptr`. Their value is don't-care while `is_valid=0`.
- Flush: next edge sets `rptr=wptr=0`. An enqueue offered in the flush cycle is dropped, and the dequeue handshake in that cycle is ignored by the sender. Flush has priority over all other updates.
- Reset (mid-operation included): same effect as flush, plus perf counters cleared.

## Timing
- Reset values: `is_valid=0`, `dec_ready=1`, perf counters 0. `is_pc`/`is_op` are unspecified.
- Latency: an instruction accepted in cycle N is visible on `is_valid` in cycle N+1. There is no combinational bypass.
- Throughput: one enqueue and one dequeue per cycle.
- Head stability: while `is_valid && is_stall`, `is_pc`/`is_op` must hold stable.
- After flush or reset in cycle N: `is_valid=0` and `dec_ready=1` in cycle N+1.

## Configuration
- `DEC_IS_PERF_EN` defined:
  - `perf_stall_cnt` increments each cycle with `is_valid && is_stall`.
  - `perf_full_cnt` increments each cycle with `count==DEPTH`.
  - Both saturate at `32'hFFFF_FFFF` and are not cleared by flush.
- `DEC_IS_PERF_EN` undefined: perf ports and counters are absent. Functional behaviour is identical.

## Structure
- `dec_op_t` (packed op bundle) and `` `DecOpWidth `` live in the shared decode header/package alongside the `DecIsIf` definition.
- The pointer-width localparam is local to this block.
- Sub-module: `dec_is_queue`, a generic synchronous FIFO providing storage, pointers and full/empty. The top level adds the flush policy, the handshake mapping and the perf counters.
- Top level binds to `DecIsIf` through its decoder-side modport.

## Test plan
- **Reset then idle:** hold `reset_=1` for 2 cycles, then release. Expect `is_valid=0`, `dec_ready=1`, and counters 0 with perf enabled.
- **Single transfer:** enqueue PC `0x100` in cycle 5 with `is_stall=0`. Expect `is_valid=1` and `is_pc=0x100` in cycle 6, and `is_valid=0` in cycle 7.
- **Fill to full:** `is_stall=1`, offer 5 instructions (PC `0x0`, `0x4`, `0x8`, `0xC`, `0x10`) with `DEPTH=4`.
  - Expect 4 accepted and `dec_ready=0`.
  - `0x10` is held off until a dequeue, and head stays `0x0`.
  - `perf_full_cnt` increments each full cycle.
- **Simultaneous enqueue/dequeue at `count=2`:** count stays 2 and order is preserved. Run 3·DEPTH continuous transfers to exercise pointer wrap. Output order must equal input order.
- **Flush with queue at `count=3` and concurrent `dec_valid`:** next cycle `is_valid=0` and `dec_ready=1`. The flushed PCs never appear on `is_pc`.
- **Reset mid-stream at `count=2`:** `reset_=1` for one cycle clears the queue. The next enqueued PC appears first at the output.
